// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, opcode/NOP constants, PC step.
// The optional skid buffer is enabled by defining IF_SKID_BUF_EN.
package if_pkg;
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_SQUASH = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  localparam logic [3:0]  IF_HLT_OPC  = 4'hF;
  localparam logic [15:0] IF_NOP_WORD = 16'h0000;
  localparam logic [15:0] PC_INC      = 16'h0002;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] addr;
  } skid_entry_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction
endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// 16-bit program counter register with write enable and asynchronous reset to RESET_PC.
module pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RESET_PC;
    else if (we) q <= d;
  end
endmodule

// File: rtl/instruction_fetch.sv
// IF stage and IF/ID register: PC ownership, imem handshake, stall/redirect handling, HLT freeze.
// Define IF_SKID_BUF_EN to hold a response that arrives during a stall in a 1-entry skid buffer.
module instruction_fetch
  import if_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OPC  = IF_HLT_OPC,
  parameter logic [15:0] NOP_WORD = IF_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Stall,
  input  logic        IF_PCDisrupt,
  input  logic [15:0] IF_PCBranch,
  output logic        IMem_Req,
  output logic [15:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [15:0] IMem_Data,
  output logic [15:0] IFID_Instr,
  output logic [15:0] IFID_PC,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [1:0]  fsm_state
);
  // Handshake: IMem_Req is a level held until IMem_Ready; a cycle with Req=1 and Ready=1
  // completes the transfer, and Ready while Req=0 carries no meaning and is ignored.
  logic [1:0]  state, state_d;
  logic [15:0] pc, pc_d, sq_addr, sq_addr_d;
  logic        pc_we, ifid_load, ifid_clear, skid_full, skid_capture, skid_clear;
  logic [15:0] ld_instr, ld_addr;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .we  (pc_we),
    .d   (pc_d),
    .q   (pc)
  );

`ifdef IF_SKID_BUF_EN
  skid_entry_t skid_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_q    <= '0;
    end else if (skid_clear) begin
      skid_full <= 1'b0;
    end else if (skid_capture) begin
      skid_full <= 1'b1;
      skid_q    <= '{data: IMem_Data, addr: pc};
    end
  end
`else
  assign skid_full = 1'b0;
`endif

  assign IMem_Req   = !rst && ((state == ST_FETCH && !skid_full) || state == ST_SQUASH);
  assign IMem_Addr  = (state == ST_SQUASH) ? sq_addr : pc;
  assign Halted     = (state == ST_HALT);
  assign fsm_state  = state;

  always_comb begin
    state_d      = state;
    pc_we        = 1'b0;
    pc_d         = pc;
    sq_addr_d    = sq_addr;
    ifid_load    = 1'b0;
    ifid_clear   = 1'b0;
    skid_capture = 1'b0;
    skid_clear   = 1'b0;
    ld_instr     = IMem_Data;
    ld_addr      = pc;
    if (IF_PCDisrupt) begin
      pc_we      = 1'b1;
      pc_d       = IF_PCBranch;
      ifid_clear = 1'b1;
      skid_clear = 1'b1;
      // An unanswered request must still be drained; remember the address it went out on.
      if (IMem_Req && !IMem_Ready) begin
        state_d = ST_SQUASH;
        if (state == ST_FETCH) sq_addr_d = pc;
      end else begin
        state_d = ST_FETCH;
      end
    end else if (IF_Stall) begin
      if (state == ST_SQUASH && IMem_Ready) state_d = ST_FETCH;
`ifdef IF_SKID_BUF_EN
      else if (state == ST_FETCH && IMem_Req && IMem_Ready) skid_capture = 1'b1;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
`ifdef IF_SKID_BUF_EN
          if (skid_full) begin
            ifid_load  = 1'b1;
            skid_clear = 1'b1;
            ld_instr   = skid_q.data;
            ld_addr    = skid_q.addr;
          end else
`endif
          if (IMem_Req && IMem_Ready) ifid_load = 1'b1;
          if (ifid_load) begin
            if (opcode_of(ld_instr) == HLT_OPC) begin
              state_d = ST_HALT;
            end else begin
              pc_we = 1'b1;
              pc_d  = ld_addr + PC_INC;
            end
          end
        end
        ST_SQUASH: if (IMem_Ready) state_d = ST_FETCH;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      sq_addr <= '0;
    end else begin
      state   <= state_d;
      sq_addr <= sq_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IFID_Instr <= NOP_WORD;
      IFID_PC    <= '0;
      IFID_Valid <= 1'b0;
    end else if (ifid_clear) begin
      IFID_Instr <= NOP_WORD;
      IFID_Valid <= 1'b0;
    end else if (ifid_load) begin
      IFID_Instr <= ld_instr;
      IFID_PC    <= ld_addr + PC_INC;
      IFID_Valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected IF/ID words, a monitor pops them.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        IF_Stall, IF_PCDisrupt;
  logic [15:0] IF_PCBranch;
  logic        IMem_Req, IMem_Ready;
  logic [15:0] IMem_Addr, IMem_Data;
  logic [15:0] IFID_Instr, IFID_PC;
  logic        IFID_Valid, Halted;
  logic [1:0]  fsm_state;

  logic        rdy_en, tog_mode, tog;
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .IF_Stall(IF_Stall), .IF_PCDisrupt(IF_PCDisrupt),
    .IF_PCBranch(IF_PCBranch), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
    .IMem_Ready(IMem_Ready), .IMem_Data(IMem_Data), .IFID_Instr(IFID_Instr),
    .IFID_PC(IFID_PC), .IFID_Valid(IFID_Valid), .Halted(Halted), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: fixed words at a few addresses, opcode-1 filler elsewhere
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1123;
      16'h0002: return 16'h2456;
      16'h0006: return 16'hF000;
      default:  return {4'h1, a[11:0]};
    endcase
  endfunction

  always_comb begin
    IMem_Ready = tog_mode ? tog : (rdy_en & IMem_Req);
    IMem_Data  = mem_word(IMem_Addr);
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic d, input logic s, input logic [15:0] br, input logic r);
    @(posedge clk);
    #1;
    IF_PCDisrupt = d;
    IF_Stall     = s;
    IF_PCBranch  = br;
    rdy_en       = r;
    #2;
  endtask

  // scoreboard monitor
  logic        last_v = 1'b0;
  logic [31:0] last_w = '0;
  always @(negedge clk) begin
    if (rst) begin
      last_v = 1'b0;
    end else begin
      if (IFID_Valid && (!last_v || {IFID_Instr, IFID_PC} != last_w)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ifid_unexpected: got %h expected none", {IFID_Instr, IFID_PC});
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if ({IFID_Instr, IFID_PC} !== e) begin
            n_fail++;
            $display("FAIL ifid_word: got %h expected %h", {IFID_Instr, IFID_PC}, e);
          end
        end
      end
      last_v = IFID_Valid;
      last_w = {IFID_Instr, IFID_PC};
    end
  end

  initial begin
    rst = 1'b1; IF_Stall = 1'b0; IF_PCDisrupt = 1'b0; IF_PCBranch = '0;
    rdy_en = 1'b0; tog_mode = 1'b1; tog = 1'b0;

    // T1 reset with Ready toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; tog = ~tog; #2;
      chk("rst_req", {31'd0, IMem_Req}, 32'd0);
      chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
      chk("rst_halted", {31'd0, Halted}, 32'd0);
    end
    chk("rst_instr", {16'd0, IFID_Instr}, 32'h0000);
    @(posedge clk); #1; rst = 1'b0; tog_mode = 1'b0; rdy_en = 1'b0; #2;
    chk("post_rst_addr", {16'd0, IMem_Addr}, 32'h0000);
    chk("post_rst_req", {31'd0, IMem_Req}, 32'd1);

    // T2 zero-wait stream
    exp_q.push_back({16'h1123, 16'h0002});
    exp_q.push_back({16'h2456, 16'h0004});
    step(0, 0, 16'h0, 1);
    chk("t2_addr0", {16'd0, IMem_Addr}, 32'h0000);
    step(0, 0, 16'h0, 1);
    chk("t2_addr1", {16'd0, IMem_Addr}, 32'h0002);
    chk("t2_pc1", {15'd0, IFID_Valid, IFID_PC}, {15'd0, 1'b1, 16'h0002});
    step(0, 0, 16'h0, 0);
    chk("t2_pc2", {15'd0, IFID_Valid, IFID_PC}, {15'd0, 1'b1, 16'h0004});

    // T3 stall with Ready high
    exp_q.push_back({16'h1004, 16'h0006});
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'h0, 1);
      chk("t3_frozen", {IFID_Instr, IFID_PC}, {16'h2456, 16'h0004});
`ifdef IF_SKID_BUF_EN
      chk("t3_skid_req", {31'd0, IMem_Req}, (i == 0) ? 32'd1 : 32'd0);
`else
      chk("t3_addr", {15'd0, IMem_Req, IMem_Addr}, {15'd0, 1'b1, 16'h0004});
`endif
    end
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    chk("t3_after", {IFID_PC, IMem_Addr}, {16'h0006, 16'h0006});

    // T4 redirect while waiting -> SQUASH; late response (an HLT word) is discarded
    step(1, 0, 16'h0040, 0);
    step(0, 0, 16'h0, 0);
    chk("t4_sq_addr", {15'd0, IMem_Req, IMem_Addr}, {15'd0, 1'b1, 16'h0006});
    chk("t4_state", {30'd0, fsm_state}, 32'd1);
    chk("t4_valid", {31'd0, IFID_Valid}, 32'd0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    chk("t4_new_addr", {16'd0, IMem_Addr}, 32'h0040);
    chk("t4_valid2", {30'd0, IFID_Valid, Halted}, 32'd0);
    chk("t4_state2", {30'd0, fsm_state}, 32'd0);
    exp_q.push_back({16'h1040, 16'h0042});
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    chk("t4_fetch", {15'd0, IFID_Valid, IFID_PC}, {15'd0, 1'b1, 16'h0042});

    // T5 disrupt and stall together: disrupt wins
    step(1, 1, 16'h0100, 1);
    step(0, 0, 16'h0, 0);
    chk("t5_addr", {16'd0, IMem_Addr}, 32'h0100);
    chk("t5_bubble", {15'd0, IFID_Valid, IFID_Instr}, 32'h0000_0000);
    chk("t5_state", {30'd0, fsm_state}, 32'd0);

    // T6 HLT, then redirect out of HALT to 0xFFFE for the wrap case
    step(1, 0, 16'h0006, 1);
    exp_q.push_back({16'hF000, 16'h0008});
    step(0, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'h0, 1);
      chk("t6_halted", {30'd0, Halted, IMem_Req}, {30'd0, 1'b1, 1'b0});
      chk("t6_pc_hold", {IMem_Addr, IFID_Instr}, {16'h0006, 16'hF000});
    end
    step(1, 0, 16'hFFFE, 0);
    exp_q.push_back({16'h1FFE, 16'h0000});
    step(0, 0, 16'h0, 1);
    chk("t6_wrap_addr", {15'd0, Halted, IMem_Addr}, {15'd0, 1'b0, 16'hFFFE});
    step(0, 0, 16'h0, 0);
    chk("t6_wrap_pc", {IMem_Addr, IFID_PC}, {16'h0000, 16'h0000});

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
